// File: rtl/image_raster_draw.sv
// Raster frame drawer: scans SCR_W x SCR_H pixels, fetches from ROMs, composes RGB888 per mode.
// Latency: 1 cycle from address to colour_out; one pixel per cycle while scanning.
// No backpressure: once started a frame streams to completion; start is ignored while busy.
module image_raster_draw #(
    parameter int          SCR_W = 160,
    parameter int          SCR_H = 120,
    parameter int          OV_W  = 80,
    parameter int          OV_H  = 40,
    parameter int          OV_X  = 40,
    parameter int          OV_Y  = 40,
    parameter logic [11:0] KEY   = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [23:0] fill_colour,
    output logic [16:0] bg_addr,
    input  logic [23:0] bg_q,
    output logic [16:0] full_addr,
    input  logic [11:0] full_q,
    output logic [16:0] ov_addr,
    input  logic [11:0] ov_q,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic [23:0] colour_out,
    output logic        pix_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]  X_LAST = 8'(SCR_W - 1);
    localparam logic [7:0]  Y_LAST = 8'(SCR_H - 1);
    localparam logic [16:0] W17    = 17'(SCR_W);
    localparam logic [16:0] OVX17  = 17'(OV_X);
    localparam logic [16:0] OVY17  = 17'(OV_Y);
    localparam logic [16:0] OVW17  = 17'(OV_W);
    localparam logic [8:0]  OVX_LO = 9'(OV_X);
    localparam logic [8:0]  OVX_HI = 9'(OV_X + OV_W);
    localparam logic [8:0]  OVY_LO = 9'(OV_Y);
    localparam logic [8:0]  OVY_HI = 9'(OV_Y + OV_H);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} stateT;

    stateT       state;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  modeLat;
    logic [23:0] fillLat;
    logic        inOv;
    logic        stgValid;
    logic        stgInOv;
    logic [7:0]  stgX;
    logic [7:0]  stgY;
    logic [23:0] lastColour;
    logic [23:0] newColour;

    // Each 4-bit channel n widens to n*17, i.e. the nibble repeated.
    function automatic logic [23:0] expand(input logic [11:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

    assign inOv = ({1'b0, x} >= OVX_LO) && ({1'b0, x} < OVX_HI) &&
                  ({1'b0, y} >= OVY_LO) && ({1'b0, y} < OVY_HI);

    assign bg_addr   = 17'(x) + 17'(y) * W17;
    assign full_addr = bg_addr;
    assign ov_addr   = inOv ? ((17'(x) - OVX17) + (17'(y) - OVY17) * OVW17) : 17'd0;

    // Frame sequencer: latches the request, walks the raster, then flushes and pulses done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            x       <= 8'd0;
            y       <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            modeLat <= 2'd0;
            fillLat <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        modeLat <= mode;
                        fillLat <= fill_colour;
                        x       <= 8'd0;
                        y       <= 8'd0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (x == X_LAST) begin
                        x <= 8'd0;
                        if (y == Y_LAST) begin
                            y     <= 8'd0;
                            state <= FLUSH;
                        end else begin
                            y <= y + 8'd1;
                        end
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline stage so coordinates and overlay flag line up with the ROM read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stgValid <= 1'b0;
            stgInOv  <= 1'b0;
            stgX     <= 8'd0;
            stgY     <= 8'd0;
        end else begin
            stgValid <= (state == SCAN);
            if (state == SCAN) begin
                stgX    <= x;
                stgY    <= y;
                stgInOv <= inOv;
            end
        end
    end

    // Pixel colour selection from the ROM data arriving this cycle.
    always_comb begin
        newColour = bg_q;
        case (modeLat)
            2'd0: newColour = bg_q;
            2'd1: newColour = expand(full_q);
            2'd2: newColour = (stgInOv && (ov_q != KEY)) ? expand(ov_q) : bg_q;
            default: newColour = fillLat;
        endcase
    end

    // Remember the last presented colour so the output holds between valid pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastColour <= 24'd0;
        end else if (stgValid) begin
            lastColour <= newColour;
        end
    end

    assign pix_valid  = stgValid;
    assign x_out      = stgX;
    assign y_out      = stgY;
    assign colour_out = stgValid ? newColour : lastColour;

endmodule

// File: tb/tb_image_raster_draw.sv
module tb_image_raster_draw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Small 4x3 instance
    logic        startA;
    logic [1:0]  modeA;
    logic [23:0] fillA;
    logic [16:0] bgAddrA, fullAddrA, ovAddrA;
    logic [23:0] bgQA;
    logic [11:0] fullQA, ovQA;
    logic [7:0]  xA, yA;
    logic [23:0] colA;
    logic        validA, busyA, doneA;

    // Default-parameter instance
    logic        startB;
    logic [1:0]  modeB;
    logic [23:0] fillB;
    logic [16:0] bgAddrB, fullAddrB, ovAddrB;
    logic [23:0] bgQB;
    logic [11:0] fullQB, ovQB;
    logic [7:0]  xB, yB;
    logic [23:0] colB;
    logic        validB, busyB, doneB;

    int vectors = 0;
    int miscompares = 0;

    image_raster_draw #(.SCR_W(4), .SCR_H(3), .OV_W(2), .OV_H(1), .OV_X(1), .OV_Y(1), .KEY(12'h000)) dutA (
        .clk(clk), .reset(reset), .start(startA), .mode(modeA), .fill_colour(fillA),
        .bg_addr(bgAddrA), .bg_q(bgQA), .full_addr(fullAddrA), .full_q(fullQA),
        .ov_addr(ovAddrA), .ov_q(ovQA), .x_out(xA), .y_out(yA), .colour_out(colA),
        .pix_valid(validA), .busy(busyA), .done(doneA)
    );

    image_raster_draw dutB (
        .clk(clk), .reset(reset), .start(startB), .mode(modeB), .fill_colour(fillB),
        .bg_addr(bgAddrB), .bg_q(bgQB), .full_addr(fullAddrB), .full_q(fullQB),
        .ov_addr(ovAddrB), .ov_q(ovQB), .x_out(xB), .y_out(yB), .colour_out(colB),
        .pix_valid(validB), .busy(busyB), .done(doneB)
    );

    // Synchronous ROM models, one cycle read latency
    always @(posedge clk) begin
        bgQA   <= 24'(bgAddrA);
        fullQA <= 12'hF80;
        ovQA   <= 12'h0F0;
        bgQB   <= 24'h800000 | 24'(bgAddrB);
        fullQB <= 12'h000;
        ovQB   <= (ovAddrB == 17'd5) ? 12'h000 : 12'h0F0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on the 4x3 instance; poke re-requests start mid-frame and in DONE with a different mode
    task automatic frameA(input logic [1:0] m, input logic [23:0] f, input logic [23:0] expConst,
                          input bit useIdx, input bit poke);
        int k, busyCnt, doneCnt, lastC, doneC;
        logic [16:0] prevBg;
        logic [23:0] expCol;
        k = 0; busyCnt = 0; doneCnt = 0; lastC = -10; doneC = -1;
        modeA = m; fillA = f; startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        if (poke) begin
            modeA = 2'd0;
            fillA = 24'hFFFFFF;
        end
        prevBg = 17'd0;
        for (int c = 1; c <= 40; c++) begin
            if (busyA) busyCnt++;
            if (validA) begin
                expCol = useIdx ? 24'(k) : expConst;
                check("xA", 32'(xA), 32'(k % 4));
                check("yA", 32'(yA), 32'(k / 4));
                check("colA", 32'(colA), 32'(expCol));
                check("bgAddrA", 32'(prevBg), 32'(k));
                k++;
                lastC = c;
            end
            if (doneA) begin
                doneCnt++;
                doneC = c;
            end
            prevBg = bgAddrA;
            startA = poke && (c == 5 || c == 14);
            @(negedge clk);
        end
        startA = 1'b0;
        check("pixCountA", 32'(k), 32'd12);
        check("doneCountA", 32'(doneCnt), 32'd1);
        check("doneAfterLastA", 32'(doneC), 32'(lastC + 1));
        check("busyCyclesA", 32'(busyCnt), 32'd14);
    endtask

    initial begin
        int k, doneCnt, lastC, doneC, ex, ey, ovIdx;
        bit inOv, sawDone;
        logic [16:0] prevOv, prevBg;
        logic [23:0] expCol;

        reset = 1'b1;
        startA = 1'b0; modeA = 2'd0; fillA = 24'd0;
        startB = 1'b0; modeB = 2'd0; fillB = 24'd0;
        #12;
        check("rst busyA", 32'(busyA), 32'd0);
        check("rst doneA", 32'(doneA), 32'd0);
        check("rst validA", 32'(validA), 32'd0);
        check("rst colA", 32'(colA), 32'd0);
        check("rst xA", 32'(xA), 32'd0);
        check("rst yA", 32'(yA), 32'd0);
        check("rst busyB", 32'(busyB), 32'd0);
        check("rst colB", 32'(colB), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Background, full-screen image, and solid fill with ignored re-starts
        frameA(2'd0, 24'h000000, 24'h000000, 1'b1, 1'b0);
        frameA(2'd1, 24'h000000, 24'hFF8800, 1'b0, 1'b0);
        frameA(2'd3, 24'h123456, 24'h123456, 1'b0, 1'b1);

        // Default instance: abort with reset after 50 valid pixels
        modeB = 2'd2; startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        k = 0; sawDone = 1'b0;
        for (int c = 0; c < 200 && k < 50; c++) begin
            @(negedge clk);
            if (validB) k++;
            if (doneB) sawDone = 1'b1;
        end
        check("abortReached", 32'(k), 32'd50);
        #2 reset = 1'b1;
        #1;
        check("abort validB", 32'(validB), 32'd0);
        check("abort colB", 32'(colB), 32'd0);
        check("abort xB", 32'(xB), 32'd0);
        check("abort yB", 32'(yB), 32'd0);
        check("abort busyB", 32'(busyB), 32'd0);
        check("abort doneB", 32'(doneB), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (doneB) sawDone = 1'b1;
        end
        check("abortNoDone", 32'(sawDone), 32'd0);

        // Fresh full frame, background plus overlay with one keyed overlay texel
        modeB = 2'd2; startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        k = 0; doneCnt = 0; lastC = -10; doneC = -1;
        prevOv = 17'd0; prevBg = 17'd0;
        for (int c = 1; c <= 19300; c++) begin
            if (validB) begin
                ex = k % 160;
                ey = k / 160;
                inOv = (ex >= 40) && (ex < 120) && (ey >= 40) && (ey < 80);
                ovIdx = inOv ? ((ex - 40) + (ey - 40) * 80) : 0;
                expCol = (inOv && ovIdx != 5) ? 24'h00FF00 : (24'h800000 | 24'(k));
                check("xB", 32'(xB), 32'(ex));
                check("yB", 32'(yB), 32'(ey));
                check("colB", 32'(colB), 32'(expCol));
                check("ovAddrB", 32'(prevOv), 32'(ovIdx));
                check("bgAddrB", 32'(prevBg), 32'(k));
                k++;
                lastC = c;
            end
            if (doneB) begin
                doneCnt++;
                doneC = c;
            end
            prevOv = ovAddrB;
            prevBg = bgAddrB;
            if (doneCnt > 0 && c > doneC + 3) break;
            @(negedge clk);
        end
        check("pixCountB", 32'(k), 32'd19200);
        check("doneCountB", 32'(doneCnt), 32'd1);
        check("doneAfterLastB", 32'(doneC), 32'(lastC + 1));
        check("idleBusyB", 32'(busyB), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
